// File: rtl/faddsub_pipe.sv
// rtl/faddsub_pipe.sv - elastic 3-stage IEEE-754 single-precision add/sub (optional FADDSUB_RNE_EN: round to nearest even)
module faddsub_pipe #(
    parameter int TAGW = 5,
    parameter int FTZ  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     x1,
    input  logic [31:0]     x2,
    input  logic            op,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     y,
    output logic            ovf,
    output logic            unf,
    output logic [TAGW-1:0] tag_out
);

    generate
        if (FTZ != 1) begin : g_ftz_check
            $error("faddsub_pipe: FTZ=0 (denormal support) is reserved");
        end
        if (TAGW < 1) begin : g_tagw_check
            $error("faddsub_pipe: TAGW must be >= 1");
        end
    endgenerate

    typedef struct packed {
        logic            sign;
        logic [7:0]      exp;
        logic [25:0]     lm;
        logic [25:0]     sm;
        logic            st;
        logic            sub;
        logic            spec;
        logic [31:0]     spec_y;
        logic [TAGW-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic            sign;
        logic [7:0]      exp;
        logic [23:0]     mant;
        logic            g;
        logic            r;
        logic            s;
        logic [4:0]      pos;
        logic            zero;
        logic            nz;
        logic            sub;
        logic            spec;
        logic [31:0]     spec_y;
        logic [TAGW-1:0] tag;
    } s2_t;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic load1, load2, load3;
    s1_t  s1_q, s1_d, s1_new;
    s2_t  s2_q, s2_d, s2_new;
    logic [31:0]     y_q, y_d, y_new;
    logic            ovf_q, ovf_d, ovf_new, unf_q, unf_d, unf_new;
    logic [TAGW-1:0] tag_q, tag_d;

    // Stall chain: a stage loads when empty or when its content moves on.
    always_comb begin
        load3 = !v3_q || out_ready;
        load2 = !v2_q || load3;
        load1 = !v1_q || load2;
        v1_d  = load1 ? in_valid : v1_q;
        v2_d  = load2 ? v1_q     : v2_q;
        v3_d  = load3 ? v2_q     : v3_q;
    end

    assign in_ready = load1;

    // S1: sign adjust, flush denormals, order by magnitude, align the smaller mantissa.
    logic [31:0] a, b, lx, sx;
    logic [7:0]  shamt;
    logic [51:0] shifted;
    always_comb begin
        a = x1;
        b = {x2[31] ^ op, x2[30:0]};
        if (a[30:23] == 8'd0) a = {a[31], 31'd0};
        if (b[30:23] == 8'd0) b = {b[31], 31'd0};
        if (b[30:0] > a[30:0]) begin
            lx = b;
            sx = a;
        end else begin
            lx = a;
            sx = b;
        end
        s1_new.sign = lx[31];
        s1_new.exp  = lx[30:23];
        s1_new.sub  = lx[31] ^ sx[31];
        s1_new.lm   = {lx[30:23] != 8'd0, lx[22:0], 2'b00};
        shamt       = lx[30:23] - sx[30:23];
        shifted     = {sx[30:23] != 8'd0, sx[22:0], 2'b00, 26'd0} >> shamt;
        if (shamt >= 8'd26) begin
            s1_new.sm = 26'd0;
            s1_new.st = (sx[30:0] != 31'd0);
        end else begin
            s1_new.sm = shifted[51:26];
            s1_new.st = |shifted[25:0];
        end
        s1_new.spec   = (lx[30:23] == 8'hFF);
        // Opposite-signed infinities of equal magnitude have no defined sum.
        if ((lx[30:23] == 8'hFF) && (lx[22:0] == 23'd0) && (lx[31] != sx[31]) && (lx[30:0] == sx[30:0]))
            s1_new.spec_y = 32'h7FC0_0000;
        else
            s1_new.spec_y = lx;
        s1_new.tag = tag_in;
        s1_d = (load1 && in_valid) ? s1_new : s1_q;
    end

    // S2: effective add/subtract, then leading-one normalisation.
    logic [26:0] sum, norm;
    always_comb begin
        // Borrowing the sticky on subtract keeps the truncated remainder positive.
        if (s1_q.sub)
            sum = {1'b0, s1_q.lm} - {1'b0, s1_q.sm} - 27'(s1_q.st);
        else
            sum = {1'b0, s1_q.lm} + {1'b0, s1_q.sm};
        s2_new.pos = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) s2_new.pos = 5'(i);
        end
        norm          = sum << (5'd26 - s2_new.pos);
        s2_new.mant   = norm[26:3];
        s2_new.g      = norm[2];
        s2_new.r      = norm[1];
        s2_new.s      = norm[0] | s1_q.st;
        s2_new.zero   = (sum == 27'd0);
        s2_new.nz     = (sum != 27'd0) || s1_q.st;
        s2_new.sign   = s1_q.sign;
        s2_new.exp    = s1_q.exp;
        s2_new.sub    = s1_q.sub;
        s2_new.spec   = s1_q.spec;
        s2_new.spec_y = s1_q.spec_y;
        s2_new.tag    = s1_q.tag;
        s2_d = (load2 && v1_q) ? s2_new : s2_q;
    end

    // S3: round, renormalise on carry, range check and pack.
    logic              inc;
    logic [24:0]       mr;
    logic [23:0]       mant_f;
    logic signed [9:0] e;
    always_comb begin
`ifdef FADDSUB_RNE_EN
        inc = s2_q.g && (s2_q.r || s2_q.s || s2_q.mant[0]);
`else
        inc = s2_q.g;
`endif
        mr      = {1'b0, s2_q.mant} + 25'(inc);
        mant_f  = mr[24] ? mr[24:1] : mr[23:0];
        e       = $signed({2'b00, s2_q.exp}) + $signed({5'd0, s2_q.pos}) - 10'sd25 + $signed({9'd0, mr[24]});
        ovf_new = 1'b0;
        unf_new = 1'b0;
        if (s2_q.spec) begin
            y_new = s2_q.spec_y;
        end else if (s2_q.zero) begin
            y_new = {s2_q.sign & !s2_q.sub, 31'd0};
        end else if (e >= 10'sd255) begin
            y_new   = {s2_q.sign, 8'hFF, 23'd0};
            ovf_new = 1'b1;
        end else if (e <= 10'sd0) begin
            y_new   = {s2_q.sign, 31'd0};
            unf_new = s2_q.nz;
        end else begin
            y_new = {s2_q.sign, e[7:0], mant_f[22:0]};
        end
        if (load3 && v2_q) begin
            y_d   = y_new;
            ovf_d = ovf_new;
            unf_d = unf_new;
            tag_d = s2_q.tag;
        end else begin
            y_d   = y_q;
            ovf_d = ovf_q;
            unf_d = unf_q;
            tag_d = tag_q;
        end
    end

    // State registers; reset drops every in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            y_q   <= 32'd0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            tag_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            tag_q <= tag_d;
        end
    end

    assign out_valid = v3_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_faddsub_pipe.sv
// tb/tb_faddsub_pipe.sv - scoreboard bench for faddsub_pipe
`timescale 1ns/1ps
module tb_faddsub_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x1 = 32'd0;
    logic [31:0] x2 = 32'd0;
    logic        op = 1'b0;
    logic [4:0]  tag_in = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic        ovf, unf;
    logic [4:0]  tag_out;

    faddsub_pipe #(.TAGW(5), .FTZ(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .op(op), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .unf(unf), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        unf;
        logic [4:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

`ifdef FADDSUB_RNE_EN
    localparam logic [31:0] TIE_Y = 32'h3F80_0000;
`else
    localparam logic [31:0] TIE_Y = 32'h3F80_0001;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever a result transfers; also checks hold-while-stalled.
    logic        held = 1'b0;
    logic [31:0] held_y;
    logic [4:0]  held_tag;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_y", y, held_y);
                    chk("stall_tag", 32'(tag_out), 32'(held_tag));
                end
                held     = out_valid && !out_ready;
                held_y   = y;
                held_tag = tag_out;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_output: got y=%h tag=%0d expected none", y, tag_out);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("y", y, e.y);
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        chk("unf", 32'(unf), 32'(e.unf));
                        chk("tag", 32'(tag_out), 32'(e.tag));
                        if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
                    end
                end
            end
        end
    end

    // Issue one op starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o, input logic [4:0] t,
                        input logic [31:0] ey, input logic eo, input logic eu, input bit lat);
        exp_t e;
        int   guard;
        x1 = a; x2 = b; op = o; tag_in = t; in_valid = 1'b1;
        #2;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            e.y = ey; e.ovf = eo; e.unf = eu; e.tag = t; e.cyc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd3, 32'h4040_0000, 1'b0, 1'b0, 1'b1);
        drain();
        send(32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd4, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        send(32'h4120_0000, 32'h4120_0000, 1'b1, 5'd5, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd6, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
        send(32'h7F80_0000, 32'hFF80_0000, 1'b0, 5'd7, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0);
        send(32'h3F80_0000, 32'h3380_0000, 1'b0, 5'd8, TIE_Y,         1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0000, 1'b1, 5'd10, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        send(32'h0080_0000, 32'h0080_0001, 1'b1, 5'd11, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send(32'h0000_0001, 32'h3F80_0000, 1'b0, 5'd12, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        send(32'h7F80_0000, 32'h3F80_0000, 1'b0, 5'd13, 32'h7F80_0000, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back stream with the consumer stalled on relative cycles 4..7.
        fork
            begin
                send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd16, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
                send(32'h4000_0000, 32'h4000_0000, 1'b0, 5'd17, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
                send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 5'd18, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
                send(32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd19, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
                send(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd20, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
                send(32'h4080_0000, 32'h3F80_0000, 1'b1, 5'd21, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    #1;
                    chk("in_ready", 32'(in_ready), 32'(!(sb.size() >= 3 && !out_ready)));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight.
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd24, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
        send(32'h4000_0000, 32'h4000_0000, 1'b0, 5'd25, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        #3;
        chk("rst_flush_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(32'h4040_0000, 32'h3F80_0000, 1'b0, 5'd26, 32'h4080_0000, 1'b0, 1'b0, 1'b1);
        drain();
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
